// File: rtl/mpls_egress_pkg.sv
// Shared definitions for the MPLS egress blocks: scheduler state encoding
// and the destination-index width helper.
package mpls_egress_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    XFER    = 2'd1,
    DISCARD = 2'd2
  } sched_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int dest_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpls_egress_rr_pick.sv
// Rotating-priority picker: returns the first set bit of elig_i at or after
// start_i, wrapping around. Purely combinational.
module mpls_egress_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    pos     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(start_i) + k) % N;
      if (elig_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/mpls_egress_sched.sv
// Packet-granular weighted round-robin scheduler onto the shared MPLS egress
// bus, admitting a packet only when its destination port has MTU headroom.
module mpls_egress_sched
  import mpls_egress_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NUM_EGR_PORTS = 4,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int SPACE_WIDTH   = 16,
  parameter int MTU_BYTES     = 9600,
  parameter int SPACE_LAT     = 4,
  parameter int DATA_BYTES    = 4,
  // tuser is the whole destination index; the spare bit lets out-of-range
  // destinations be expressed and routed to discard.
  parameter int USER_W        = dest_w(NUM_EGR_PORTS) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [NUM_REQ-1:0]                    req_tvalid_i,
  output logic [NUM_REQ-1:0]                    req_tready_o,
  input  logic [NUM_REQ*DATA_BYTES*8-1:0]       req_tdata_i,
  input  logic [NUM_REQ*DATA_BYTES-1:0]         req_tkeep_i,
  input  logic [NUM_REQ-1:0]                    req_tlast_i,
  input  logic [NUM_REQ*USER_W-1:0]             req_tuser_i,
  output logic                                  egr_tvalid_o,
  input  logic                                  egr_tready_i,
  output logic [DATA_BYTES*8-1:0]               egr_tdata_o,
  output logic [DATA_BYTES-1:0]                 egr_tkeep_o,
  output logic                                  egr_tlast_o,
  output logic [USER_W-1:0]                     egr_tuser_o,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]       req_weight_i,
  input  logic [NUM_EGR_PORTS*SPACE_WIDTH-1:0]  egr_port_space_i,
  output logic [dest_w(NUM_REQ)-1:0]            cur_grant_o,
  output logic                                  busy_o,
  output logic                                  bad_dest_o,
  output sched_state_t                          state_o
);

  localparam int DATA_W = DATA_BYTES * 8;
  localparam int DEST_W = dest_w(NUM_EGR_PORTS);
  localparam int GNT_W  = dest_w(NUM_REQ);
  localparam int HO_W   = (SPACE_LAT > 0) ? $clog2(SPACE_LAT + 1) : 1;

  // Handshake: a beat moves on a cycle where tvalid and tready are both high;
  // tvalid never waits on tready, and tready reaches only the granted requester.

  sched_state_t      state_q, state_d;
  logic [GNT_W-1:0]  ptr_q, ptr_d;
  logic [GNT_W-1:0]  grant_q, grant_d;
  logic [WEIGHT_WIDTH-1:0] quota_q, quota_d;
  logic [USER_W-1:0] dest_q, dest_d;
  logic              bad_q, bad_d;
  logic [HO_W-1:0]   holdoff_q [NUM_EGR_PORTS];
  logic [HO_W-1:0]   holdoff_d [NUM_EGR_PORTS];
  logic              ho_load;

  logic [USER_W-1:0]       req_user   [NUM_REQ];
  logic [DATA_W-1:0]       req_data   [NUM_REQ];
  logic [DATA_BYTES-1:0]   req_keep   [NUM_REQ];
  logic [WEIGHT_WIDTH-1:0] weight     [NUM_REQ];
  logic [SPACE_WIDTH-1:0]  space      [NUM_EGR_PORTS];
  logic [NUM_REQ-1:0]      dest_bad;
  logic [NUM_REQ-1:0]      elig;
  logic [NUM_EGR_PORTS-1:0] port_ok;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign req_user[r] = req_tuser_i[r*USER_W +: USER_W];
    assign req_data[r] = req_tdata_i[r*DATA_W +: DATA_W];
    assign req_keep[r] = req_tkeep_i[r*DATA_BYTES +: DATA_BYTES];
    assign weight[r]   = req_weight_i[r*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign dest_bad[r] = int'(req_user[r]) >= NUM_EGR_PORTS;
  end

  for (genvar d = 0; d < NUM_EGR_PORTS; d++) begin : g_port
    assign space[d]   = egr_port_space_i[d*SPACE_WIDTH +: SPACE_WIDTH];
    assign port_ok[d] = (32'(space[d]) >= 32'(MTU_BYTES)) && (holdoff_q[d] == '0);
  end

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      elig[r] = 1'b0;
      if (req_tvalid_i[r] && (weight[r] != '0)) begin
        if (dest_bad[r]) elig[r] = 1'b1;
        else             elig[r] = port_ok[req_user[r][DEST_W-1:0]];
      end
    end
  end

  logic [GNT_W-1:0] scan_start;
  logic             pick_found;
  logic [GNT_W-1:0] pick_idx;

  assign scan_start = (ptr_q == GNT_W'(NUM_REQ - 1)) ? '0 : ptr_q + 1'b1;

  mpls_egress_rr_pick #(
    .N  (NUM_REQ),
    .IW (GNT_W)
  ) u_pick (
    .elig_i  (elig),
    .start_i (scan_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  logic             sticky;
  logic [GNT_W-1:0] gnt_idx;
  logic             g_valid, g_last;
  logic [WEIGHT_WIDTH-1:0] quota_dec;

  assign sticky    = elig[ptr_q] && (quota_q != '0);
  assign gnt_idx   = sticky ? ptr_q : pick_idx;
  assign g_valid   = req_tvalid_i[grant_q];
  assign g_last    = req_tlast_i[grant_q];
  assign quota_dec = (quota_q == '0) ? '0 : quota_q - 1'b1;

  // Data sidebands pass straight through; only tvalid is gated by state.
  assign egr_tdata_o = req_data[grant_q];
  assign egr_tkeep_o = req_keep[grant_q];
  assign egr_tlast_o = g_last;
  assign egr_tuser_o = req_user[grant_q];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    quota_d      = quota_q;
    dest_d       = dest_q;
    bad_d        = 1'b0;
    ho_load      = 1'b0;
    egr_tvalid_o = 1'b0;
    req_tready_o = '0;
    case (state_q)
      ARB: begin
        if (sticky || pick_found) begin
          grant_d = gnt_idx;
          dest_d  = req_user[gnt_idx];
          if (!sticky) begin
            ptr_d   = pick_idx;
            quota_d = weight[pick_idx];
          end
          if (dest_bad[gnt_idx]) begin
            state_d = DISCARD;
            bad_d   = 1'b1;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        egr_tvalid_o          = g_valid;
        req_tready_o[grant_q] = egr_tready_i;
        if (g_valid && egr_tready_i && g_last) begin
          state_d = ARB;
          quota_d = quota_dec;
          ho_load = 1'b1;
        end
      end
      DISCARD: begin
        req_tready_o[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          state_d = ARB;
          quota_d = quota_dec;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // A fresh load on the port just released takes priority over its countdown.
  always_comb begin
    for (int d = 0; d < NUM_EGR_PORTS; d++) begin
      holdoff_d[d] = holdoff_q[d];
      if (ho_load && (int'(dest_q) == d)) holdoff_d[d] = HO_W'(SPACE_LAT);
      else if (holdoff_q[d] != '0)        holdoff_d[d] = holdoff_q[d] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB;
      ptr_q   <= GNT_W'(NUM_REQ - 1);
      grant_q <= '0;
      quota_q <= '0;
      dest_q  <= '0;
      bad_q   <= 1'b0;
      for (int d = 0; d < NUM_EGR_PORTS; d++) holdoff_q[d] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      quota_q <= quota_d;
      dest_q  <= dest_d;
      bad_q   <= bad_d;
      for (int d = 0; d < NUM_EGR_PORTS; d++) holdoff_q[d] <= holdoff_d[d];
    end
  end

  assign cur_grant_o = grant_q;
  assign busy_o      = (state_q != ARB);
  assign bad_dest_o  = bad_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mpls_egress_sched.sv
// Randomized bench for mpls_egress_sched: a packet-level timing model predicts
// every egress beat and bad_dest pulse; a monitor pops and compares.
module tb_mpls_egress_sched;
  import mpls_egress_pkg::*;

  localparam int NR = 4, NP = 4, WW = 4, SW = 16, MTU = 9600, LAT = 4;
  localparam int DB = 4, DW = 32, UW = 3, GW = 2;
  localparam int EXP_W = 16 + GW + UW + 1 + DB + DW;
  localparam int MAXP = 16, T_LIM = 1500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_abs = 0;
  int base = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  logic [NR-1:0]    req_tvalid, req_tready, req_tlast;
  logic [NR*DW-1:0] req_tdata;
  logic [NR*DB-1:0] req_tkeep;
  logic [NR*UW-1:0] req_tuser;
  logic             egr_tvalid, egr_tready, egr_tlast;
  logic [DW-1:0]    egr_tdata;
  logic [DB-1:0]    egr_tkeep;
  logic [UW-1:0]    egr_tuser;
  logic [NR*WW-1:0] req_weight;
  logic [NP*SW-1:0] egr_space;
  logic [GW-1:0]    cur_grant;
  logic             busy, bad_dest;
  sched_state_t     state;

  mpls_egress_sched #(
    .NUM_REQ(NR), .NUM_EGR_PORTS(NP), .WEIGHT_WIDTH(WW), .SPACE_WIDTH(SW),
    .MTU_BYTES(MTU), .SPACE_LAT(LAT), .DATA_BYTES(DB), .USER_W(UW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_tvalid_i(req_tvalid), .req_tready_o(req_tready), .req_tdata_i(req_tdata),
    .req_tkeep_i(req_tkeep), .req_tlast_i(req_tlast), .req_tuser_i(req_tuser),
    .egr_tvalid_o(egr_tvalid), .egr_tready_i(egr_tready), .egr_tdata_o(egr_tdata),
    .egr_tkeep_o(egr_tkeep), .egr_tlast_o(egr_tlast), .egr_tuser_o(egr_tuser),
    .req_weight_i(req_weight), .egr_port_space_i(egr_space),
    .cur_grant_o(cur_grant), .busy_o(busy), .bad_dest_o(bad_dest), .state_o(state)
  );

  // ---------------- configuration / stimulus tables ----------------
  int unsigned w_cfg [NR];
  int unsigned npk   [NR];
  int unsigned pk_len  [NR][MAXP];
  int unsigned pk_dest [NR][MAXP];
  int unsigned sp_lo [NP], sp_hi [NP], sp_raise [NP];
  bit          pat [4096];
  int          pi [NR], bi [NR];
  int unsigned salt;

  logic [EXP_W-1:0] exp_q [$];
  int               bad_q [$];
  int  n_chk = 0, n_pass = 0, stray = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] beat_data(int r, int i, int b);
    return {8'(salt), 8'(r), 8'(i), 8'(b)} ^ {salt[15:0], 16'h0};
  endfunction

  function automatic logic [DB-1:0] beat_keep(int r, int i, int b, int len);
    return (b == len - 1) ? DB'((1 << ((r + i) % DB + 1)) - 1) : {DB{1'b1}};
  endfunction

  // Only the first beat's tuser routes; later beats carry unrelated values.
  function automatic logic [UW-1:0] beat_user(int dest, int b);
    return (b == 0) ? UW'(dest) : UW'((dest + 3 * b) % 8);
  endfunction

  function automatic int space_at(int d, int c);
    return (c < int'(sp_raise[d])) ? int'(sp_lo[d]) : int'(sp_hi[d]);
  endfunction

  // ---------------- reference model ----------------
  // Steps from one arbitration opportunity to the next: a port is free again
  // SPACE_LAT+1 cycles after its last beat; beats land on cycles where the
  // pre-chosen egress ready pattern is high.
  task automatic build_model(output int t_end);
    int nxt [NR];
    int free_at [NP];
    bit el [NR];
    int t, ptr, quota, remaining, g, last, c, d, len;
    t = 0; ptr = NR - 1; quota = 0; remaining = 0;
    for (int r = 0; r < NR; r++) begin
      nxt[r] = 0;
      if (w_cfg[r] != 0) remaining += int'(npk[r]);
    end
    for (int p = 0; p < NP; p++) free_at[p] = 0;
    while (remaining > 0 && t < T_LIM) begin
      for (int r = 0; r < NR; r++) begin
        el[r] = 1'b0;
        if (nxt[r] < int'(npk[r]) && w_cfg[r] != 0) begin
          d = int'(pk_dest[r][nxt[r]]);
          el[r] = (d >= NP) || (space_at(d, t) >= MTU && t >= free_at[d]);
        end
      end
      g = -1;
      if (el[ptr] && quota > 0) g = ptr;
      else begin
        for (int k = 1; k <= NR; k++) begin
          if (el[(ptr + k) % NR]) begin
            g = (ptr + k) % NR; ptr = g; quota = int'(w_cfg[g]);
            break;
          end
        end
      end
      if (g < 0) begin
        t++;
        continue;
      end
      d = int'(pk_dest[g][nxt[g]]);
      len = int'(pk_len[g][nxt[g]]);
      if (d >= NP) begin
        bad_q.push_back(t + 1);
        last = t + len;
      end else begin
        c = t + 1;
        for (int b = 0; b < len; b++) begin
          while (c < 4095 && !pat[c]) c++;
          exp_q.push_back({16'(c), GW'(g), beat_user(d, b), (b == len - 1),
                           beat_keep(g, nxt[g], b, len), beat_data(g, nxt[g], b)});
          c++;
        end
        last = c - 1;
        free_at[d] = last + 1 + LAT;
      end
      quota = (quota > 0) ? quota - 1 : 0;
      nxt[g]++;
      remaining--;
      t = last + 1;
    end
    t_end = t;
  endtask

  // ---------------- driver ----------------
  task automatic drive_all();
    int c, len;
    c = cyc_abs - base;
    if (c < 0) c = 0;
    if (c > 4095) c = 4095;
    egr_tready = pat[c];
    for (int d = 0; d < NP; d++) egr_space[d*SW +: SW] = SW'(space_at(d, c));
    for (int r = 0; r < NR; r++) begin
      req_weight[r*WW +: WW] = WW'(w_cfg[r]);
      if (pi[r] < int'(npk[r])) begin
        len = int'(pk_len[r][pi[r]]);
        req_tvalid[r]          = 1'b1;
        req_tdata[r*DW +: DW]  = beat_data(r, pi[r], bi[r]);
        req_tkeep[r*DB +: DB]  = beat_keep(r, pi[r], bi[r], len);
        req_tlast[r]           = (bi[r] == len - 1);
        req_tuser[r*UW +: UW]  = beat_user(int'(pk_dest[r][pi[r]]), bi[r]);
      end else begin
        req_tvalid[r]          = 1'b0;
        req_tdata[r*DW +: DW]  = '0;
        req_tkeep[r*DB +: DB]  = '0;
        req_tlast[r]           = 1'b0;
        req_tuser[r*UW +: UW]  = '0;
      end
    end
  endtask

  initial begin
    bit hs [NR];
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) hs[r] = req_tvalid[r] && req_tready[r];
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (hs[r]) begin
          if (bi[r] == int'(pk_len[r][pi[r]]) - 1) begin
            bi[r] = 0;
            pi[r]++;
          end else bi[r]++;
        end
      end
      drive_all();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] got, e;
    int bc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (egr_tvalid && egr_tready) begin
          got = {16'(cyc_abs - base), cur_grant, egr_tuser, egr_tlast, egr_tkeep, egr_tdata};
          check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat{cyc,gnt,user,last,keep,data}", 64'(got), 64'(e));
          end
        end
        if (bad_dest) begin
          check("bad_dest_expected", 64'(bad_q.size() != 0), 64'd1);
          if (bad_q.size() != 0) begin
            bc = bad_q.pop_front();
            check("bad_dest_cycle", 64'(cyc_abs - base), 64'(bc));
          end
        end
        if ($countones(req_tready) > 1) stray++;
      end
    end
  end

  // ---------------- phases ----------------
  task automatic cfg_clear();
    salt = $urandom();
    for (int r = 0; r < NR; r++) begin
      w_cfg[r] = 1; npk[r] = 0;
    end
    for (int d = 0; d < NP; d++) begin
      sp_lo[d] = 65535; sp_hi[d] = 65535; sp_raise[d] = 0;
    end
    for (int c = 0; c < 4096; c++) pat[c] = 1'b1;
  endtask

  task automatic add_pkt(int r, int len, int dest);
    pk_len[r][npk[r]] = len;
    pk_dest[r][npk[r]] = dest;
    npk[r]++;
  endtask

  task automatic cfg_random();
    cfg_clear();
    for (int r = 0; r < NR; r++) begin
      w_cfg[r] = $urandom_range(0, 3);
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        add_pkt(r, $urandom_range(1, 4), $urandom_range(0, 5));
    end
    w_cfg[0] = $urandom_range(1, 3);
    for (int d = 0; d < NP; d++) begin
      sp_hi[d] = ($urandom_range(0, 3) == 0) ? 9600 : $urandom_range(9600, 65535);
      sp_lo[d] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9599) : sp_hi[d];
      sp_raise[d] = $urandom_range(0, 80);
    end
    if ($urandom_range(0, 2) != 0)
      for (int c = 0; c < 4096; c++) pat[c] = ($urandom_range(0, 1) == 1);
  endtask

  task automatic run_phase(input int abort_at);
    int t_end, left;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #2;
    exp_q.delete();
    bad_q.delete();
    for (int r = 0; r < NR; r++) begin
      pi[r] = 0; bi[r] = 0;
    end
    base = cyc_abs;
    build_model(t_end);
    drive_all();
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bad_dest", 64'(bad_dest), 64'd0);
    check("rst_egr_tvalid", 64'(egr_tvalid), 64'd0);
    check("rst_req_tready", 64'(req_tready), 64'd0);
    check("rst_cur_grant", 64'(cur_grant), 64'd0);
    check("rst_state", 64'(state), 64'(ARB));
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    if (abort_at > 0) begin
      left = 0;
      foreach (exp_q[i]) if (int'(exp_q[i][EXP_W-1 -: 16]) >= abort_at) left++;
      repeat (abort_at) @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("abort_egr_tvalid", 64'(egr_tvalid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_req_tready", 64'(req_tready), 64'd0);
      check("abort_beats_left", 64'(exp_q.size()), 64'(left));
    end else begin
      repeat (t_end + 3) @(posedge clk);
      #2;
      check("beats_outstanding", 64'(exp_q.size()), 64'd0);
      check("bad_dest_outstanding", 64'(bad_q.size()), 64'd0);
    end
  endtask

  initial begin
    req_tvalid = '0; req_tdata = '0; req_tkeep = '0; req_tlast = '0; req_tuser = '0;
    egr_tready = 1'b0; req_weight = '0; egr_space = '0;
    for (int r = 0; r < NR; r++) begin
      pi[r] = 0; bi[r] = 0;
    end
    cfg_clear();
    repeat (3) @(posedge clk);

    // weighting: {2,1,0,1}, single-beat packets, one port per requester
    cfg_clear();
    w_cfg[0] = 2; w_cfg[1] = 1; w_cfg[2] = 0; w_cfg[3] = 1;
    for (int r = 0; r < NR; r++) for (int i = 0; i < 6; i++) add_pkt(r, 1, r);
    run_phase(0);

    // space gating: port 1 one byte short of MTU until cycle 20
    cfg_clear();
    add_pkt(0, 2, 1);
    sp_lo[1] = 9599; sp_hi[1] = 9600; sp_raise[1] = 20;
    run_phase(0);

    // holdoff: two packets to port 2, gap filled by a port-3 packet
    cfg_clear();
    w_cfg[0] = 2;
    add_pkt(0, 2, 2); add_pkt(0, 2, 2);
    add_pkt(1, 1, 3); add_pkt(1, 1, 3);
    run_phase(0);

    // bad destination: 3-beat packet to index 5, then requester 1 served
    cfg_clear();
    add_pkt(0, 3, 5);
    add_pkt(1, 2, 0);
    run_phase(0);

    // backpressure: 10-beat packet under random egress ready
    cfg_clear();
    for (int c = 0; c < 4096; c++) pat[c] = ($urandom_range(0, 1) == 1);
    add_pkt(0, 10, 0);
    add_pkt(2, 3, 1);
    run_phase(0);

    // asynchronous reset during beat 5 of a 10-beat packet
    cfg_clear();
    add_pkt(0, 10, 0);
    add_pkt(1, 1, 1);
    run_phase(5);

    for (int k = 0; k < 8; k++) begin
      cfg_random();
      run_phase(0);
    end

    check("stray_tready", 64'(stray), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
